// File: rtl/iter_multiplier.sv
// iter_multiplier
//   Multi-cycle DATA_W x DATA_W -> 2*DATA_W shift-add multiplier serving the
//   execute stage's start/end multiply handshake. One iteration per clock,
//   fixed latency, no early-out. Signed operands are handled by multiplying
//   magnitudes and negating the result when the operand signs differ.
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        synchronous active-low reset
//   mult_start_i   request level; operands stable while high
//   mult_signed_i  1 = two's-complement operands, 0 = unsigned
//   mult_opd1_i    multiplicand
//   mult_opd2_i    multiplier
//   mult_ack_i     EX consumed the result (only looked at in DONE)
//   product_o      registered product, valid while mult_end_o is high
//   mult_end_o     registered, high exactly while in DONE
module iter_multiplier #(
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  mult_start_i,
    input  logic                  mult_signed_i,
    input  logic [DATA_W-1:0]     mult_opd1_i,
    input  logic [DATA_W-1:0]     mult_opd2_i,
    input  logic                  mult_ack_i,
    output logic [2*DATA_W-1:0]   product_o,
    output logic                  mult_end_o
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PROD_W-1:0]   mcand_q;
    logic [DATA_W-1:0]   mplr_q;
    logic [PROD_W-1:0]   acc_q;
    logic                neg_q;

    logic [DATA_W-1:0]   opd1_abs;
    logic [DATA_W-1:0]   opd2_abs;
    logic [PROD_W-1:0]   acc_next;
    logic [PROD_W-1:0]   prod_next;

    always_comb begin
        // |most-negative| wraps to itself, which is the correct unsigned magnitude.
        opd1_abs  = (mult_signed_i && mult_opd1_i[DATA_W-1]) ? -mult_opd1_i : mult_opd1_i;
        opd2_abs  = (mult_signed_i && mult_opd2_i[DATA_W-1]) ? -mult_opd2_i : mult_opd2_i;
        acc_next  = acc_q + (mplr_q[0] ? mcand_q : '0);
        // Magnitude product never exceeds 2^(2*DATA_W-2), so negation cannot overflow.
        prod_next = neg_q ? -acc_next : acc_next;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplr_q     <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            product_o  <= '0;
            mult_end_o <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mult_start_i) begin
                        mcand_q <= {{DATA_W{1'b0}}, opd1_abs};
                        mplr_q  <= opd2_abs;
                        neg_q   <= mult_signed_i & (mult_opd1_i[DATA_W-1] ^ mult_opd2_i[DATA_W-1]);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Request withdrawn (pipeline flush): drop the operation silently.
                    if (!mult_start_i) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q   <= acc_next;
                        mcand_q <= mcand_q << 1;
                        mplr_q  <= mplr_q >> 1;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == LAST_IT) begin
                            product_o  <= prod_next;
                            mult_end_o <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Always pass through IDLE so a held start re-samples fresh operands.
                    if (mult_ack_i || !mult_start_i) begin
                        mult_end_o <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    mult_end_o <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/iter_multiplier.md
# iter_multiplier

Multi-cycle 32×32→64 iterative multiplier that answers the execute stage's start/end multiply handshake. The execute stage holds `mult_start_i` high with operands stable while a multiply sits in EX. This block computes the product over 32 shift-add iterations and raises `mult_end_o` with a registered `product_o`. It holds that result until the execute stage acknowledges it or withdraws the request. Signed and unsigned forms share one datapath via sign-magnitude correction.

## Interface
- `DATA_W`, 32: operand width; product width is `2*DATA_W`; iteration counter width is `$clog2(DATA_W)`.
- `clk_i` input 1: clock; all state updates on rising edge.
- `rst_n_i` input 1: reset, one clock; synchronous, active-low.
- `mult_start_i` input 1: request, level; operands valid and stable while high.
- `mult_signed_i` input 1: 1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- `mult_opd1_i` input DATA_W: multiplicand.
- `mult_opd2_i` input DATA_W: multiplier.
- `mult_ack_i` input 1: EX consumed the result (stage advancing); meaningful only in DONE.
- `product_o` output 2*DATA_W: registered product; valid while `mult_end_o` is high.
- `mult_end_o` output 1: registered; high exactly while in DONE.

## Operation
- States: IDLE, BUSY, DONE.
- **Reset.** While `rst_n_i` is 0 at an edge, the next state is IDLE, `product_o` = 0, `mult_end_o` = 0, and the counter and accumulators are 0. Reset mid-BUSY or mid-DONE discards the operation.
- **IDLE → BUSY** when `mult_start_i` = 1. On that edge:
  - mcand_q = |opd1| (zero-extended to 2*DATA_W); mplr_q = |opd2|.
  - neg_q = `mult_signed_i` & (opd1[31] ^ opd2[31]); acc_q = 0; cnt_q = 0.
  - Abs is applied only when `mult_signed_i` = 1. |0x80000000| = 0x80000000 as unsigned 32-bit, so no overflow.
- **BUSY, one iteration per edge:**
  - if mplr_q[0], acc_q += mcand_q.
  - mcand_q <<= 1; mplr_q >>= 1; cnt_q += 1.
  - On the iteration with cnt_q = 31, `product_o` is loaded with neg_q ? −(acc_next) : acc_next (64-bit two's complement). The state then goes to DONE.
- **BUSY abort.** `mult_start_i` = 0 in BUSY → IDLE next edge with no result. This covers a pipeline flush. `mult_end_o` stays 0.
- **DONE:**
  - `mult_end_o` = 1; `product_o` holds.
  - `mult_ack_i` = 1 or `mult_start_i` = 0 → IDLE next edge; `mult_end_o` falls.
  - Otherwise DONE holds indefinitely, covering EX stalled by a downstream stage.
- **Back-to-back.** `mult_ack_i` = 1 with `mult_start_i` = 1 in DONE → IDLE. The start still high in the next cycle is taken as a new request with the new operands. There is no direct DONE → BUSY path.
- Operands are not re-sampled during BUSY or DONE. Operand changes there have no effect.
- Magnitude product ≤ 2^62, so 64-bit negation never overflows. The low 32 bits are identical for signed and unsigned modes.

## Timing
- Start sampled high in IDLE at the end of cycle n → BUSY in cycles n+1..n+32 → `mult_end_o` = 1 from cycle n+33. Fixed latency is 33 cycles with no early-out.
- Minimum request-to-request spacing is 34 cycles: 33 + the DONE→IDLE cycle.
- All outputs are registered; there are no combinational input→output paths.
- `mult_ack_i` when not in DONE is ignored.

## Test plan
- **Unsigned max.** Signed = 0, opd1 = opd2 = 0xFFFFFFFF, start held, ack pulsed on first end.
  - `mult_end_o` rises exactly 33 cycles after start is first sampled.
  - `product_o` = 0xFFFFFFFE_00000001.
  - IDLE one cycle after the ack.
- **Signed mixed and corner.**
  - −3 × 5 → 0xFFFFFFFF_FFFFFFF1.
  - 0x80000000 × 0x80000000 signed → 0x40000000_00000000.
  - 0x80000000 × 0x80000000 unsigned → 0x40000000_00000000.
  - 7 × 0 → 0.
- **Abort.** Start drops 10 cycles into BUSY.
  - IDLE next cycle; `mult_end_o` never asserts.
  - A new start 2 cycles later yields the correct product 33 cycles after its sampling.
- **Stall then release.** Hold start, no ack, for 20 cycles after end.
  - `mult_end_o` and `product_o` are stable throughout.
  - Dropping start → IDLE, end = 0 next cycle.
- **Back-to-back.** Ack with start held and operands changed to 6 × 7 in the same cycle.
  - One IDLE cycle follows.
  - Second `mult_end_o` is 34 cycles after the first ack; `product_o` = 42.
- **Reset mid-op.** `rst_n_i` low for 1 cycle at BUSY cycle 15.
  - Next cycle: IDLE, `product_o` = 0, `mult_end_o` = 0.
  - A subsequent request completes normally.
